// File: rtl/bj_card_pkg.sv
// Shared types and helpers for the card shoe.
// Contents: deck geometry constants, card encoding {suit, rank},
// FSM state enum, blackjack value mapping and shuffle index mask.
package bj_card_pkg;

  localparam int DECK_SIZE = 52;
  localparam int NUM_RANKS = 13;
  localparam int NUM_SUITS = 4;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    SHUFFLE = 2'd1,
    READY   = 2'd2
  } state_t;

  // Face cards count as 10.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    if (rank >= 4'd10) begin
      return 4'd10;
    end else begin
      return rank;
    end
  endfunction

  // Smallest 2^k-1 that covers index i, so a masked LFSR draw has a
  // good chance of landing in 0..i.
  function automatic logic [5:0] index_mask(input logic [5:0] i);
    if (i >= 6'd32) begin
      return 6'd63;
    end else if (i >= 6'd16) begin
      return 6'd31;
    end else if (i >= 6'd8) begin
      return 6'd15;
    end else if (i >= 6'd4) begin
      return 6'd7;
    end else if (i >= 6'd2) begin
      return 6'd3;
    end else begin
      return 6'd1;
    end
  endfunction

endpackage

// File: rtl/bj_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, free running outside reset.
// Ports: clk, reset (sync active-low, loads seed), seed (non-zero start
// value), q (current register contents).
module bj_lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
  assign q    = r_q;

  // Shift register with seed load on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= seed;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: fills a deck, Fisher-Yates shuffles it with an LFSR and
// deals one card per request, refilling on exhaustion or at a round
// boundary when the deck is low.
// Ports: clk, reset (sync active-low), test_mode (fixed order, no shuffle),
// new_round (round-end pulse), req (deal request), card_valid/card_rank/
// card_suit/card_value (dealt card), cards_left (undealt count),
// busy (fill/shuffle in progress; requests are remembered).
module card_shoe
  import bj_card_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned RESHUFFLE_AT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       test_mode,
  input  logic       new_round,
  input  logic       req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       busy
);

  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
  localparam logic [5:0] DECK_END = 6'(DECK_SIZE);
  localparam logic [5:0] RESH_AT  = 6'(RESHUFFLE_AT);

  state_t     r_state;
  state_t     w_state_nxt;
  card_t      r_deck [0:DECK_SIZE-1];
  logic [5:0] r_i;
  logic [5:0] r_ptr;
  logic       r_pend_req;
  logic       r_pend_shuf;
  logic       r_test_mode;
  logic [15:0] w_lfsr;
  logic [5:0] w_j;
  card_t      w_fill_card;
  logic       w_deal;
  logic       w_swap;
  logic       w_pend_nxt;
  logic       w_shuf_nxt;

  bj_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (w_lfsr)
  );

  assign w_j              = w_lfsr[5:0] & index_mask(r_i);
  assign w_fill_card.suit = 2'(r_i / 6'(NUM_RANKS));
  assign w_fill_card.rank = 4'(r_i % 6'(NUM_RANKS)) + 4'd1;

  // Next-state and per-cycle control decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_deal      = 1'b0;
    w_swap      = 1'b0;
    w_pend_nxt  = r_pend_req;
    w_shuf_nxt  = r_pend_shuf;
    case (r_state)
      FILL: begin
        w_shuf_nxt = 1'b0;
        if (req) begin
          w_pend_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend_req;
        end
        if (r_i == LAST_IDX) begin
          w_state_nxt = r_test_mode ? READY : SHUFFLE;
        end else begin
          w_state_nxt = FILL;
        end
      end
      SHUFFLE: begin
        if (req) begin
          w_pend_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend_req;
        end
        // Out-of-range draws are rejected; retry with the next LFSR value.
        if (w_j <= r_i) begin
          w_swap = 1'b1;
          if (r_i == 6'd1) begin
            w_state_nxt = READY;
          end else begin
            w_state_nxt = SHUFFLE;
          end
        end else begin
          w_swap = 1'b0;
        end
      end
      READY: begin
        if (r_pend_shuf) begin
          // Reshuffle deferred from a deal that coincided with new_round.
          w_state_nxt = FILL;
          w_shuf_nxt  = 1'b0;
          w_pend_nxt  = req | r_pend_req;
        end else if (req || r_pend_req) begin
          if (r_ptr == DECK_END) begin
            w_pend_nxt  = 1'b1;
            w_state_nxt = FILL;
          end else begin
            w_deal     = 1'b1;
            w_pend_nxt = 1'b0;
            if (new_round && ((cards_left - 6'd1) < RESH_AT)) begin
              w_shuf_nxt = 1'b1;
            end else begin
              w_shuf_nxt = 1'b0;
            end
          end
        end else if (new_round && (cards_left < RESH_AT)) begin
          w_state_nxt = FILL;
        end else begin
          w_state_nxt = READY;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Index, pointer, pending flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_i         <= 6'd0;
      r_ptr       <= DECK_END;
      cards_left  <= 6'd0;
      r_pend_req  <= 1'b0;
      r_pend_shuf <= 1'b0;
      r_test_mode <= 1'b0;
      card_valid  <= 1'b0;
      card_rank   <= 4'd0;
      card_suit   <= 2'd0;
      card_value  <= 4'd0;
      busy        <= 1'b1;
    end else begin
      r_pend_req  <= w_pend_nxt;
      r_pend_shuf <= w_shuf_nxt;
      card_valid  <= w_deal;
      busy        <= (w_state_nxt != READY);
      case (r_state)
        FILL: begin
          if (r_i == 6'd0) begin
            r_test_mode <= test_mode;
          end
          if (r_i == LAST_IDX) begin
            r_ptr      <= 6'd0;
            cards_left <= DECK_END;
            r_i        <= LAST_IDX;
          end else begin
            r_i <= r_i + 6'd1;
          end
        end
        SHUFFLE: begin
          if (w_swap) begin
            r_i <= r_i - 6'd1;
          end
        end
        READY: begin
          if (w_deal) begin
            card_rank  <= r_deck[r_ptr].rank;
            card_suit  <= r_deck[r_ptr].suit;
            card_value <= rank_to_value(r_deck[r_ptr].rank);
            r_ptr      <= r_ptr + 6'd1;
            cards_left <= cards_left - 6'd1;
          end
          if (w_state_nxt == FILL) begin
            r_i <= 6'd0;
          end
        end
        default: begin
          r_i <= 6'd0;
        end
      endcase
    end
  end

  // Deck storage: sequential fill, then in-place swaps during the shuffle.
  always_ff @(posedge clk) begin
    if (r_state == FILL) begin
      r_deck[r_i] <= w_fill_card;
    end else if (w_swap) begin
      r_deck[r_i] <= r_deck[w_j];
      r_deck[w_j] <= r_deck[r_i];
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       test_mode = 1'b0;
  logic       new_round = 1'b0;
  logic       req = 1'b0;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       busy;

  card_shoe dut (
    .clk        (clk),
    .reset      (reset),
    .test_mode  (test_mode),
    .new_round  (new_round),
    .req        (req),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_suit  (card_suit),
    .card_value (card_value),
    .cards_left (cards_left),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       any;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] value;
    logic [5:0] left;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] cap_q[$];
  logic [5:0] ref_seq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int rel_cyc = 0;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ord(input int k, input int left, input int at);
    exp_t e;
    int r;
    r       = (k % 13) + 1;
    e.any   = 1'b0;
    e.rank  = 4'(r);
    e.suit  = 2'(k / 13);
    e.value = (r >= 10) ? 4'd10 : 4'(r);
    e.left  = 6'(left);
    e.at    = at;
    return e;
  endfunction

  function automatic exp_t wild(input int left, input int at);
    exp_t e;
    e.any   = 1'b1;
    e.rank  = 4'd0;
    e.suit  = 2'd0;
    e.value = 4'd0;
    e.left  = 6'(left);
    e.at    = at;
    return e;
  endfunction

  // Monitor: every card_valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (card_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected card_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        cap_q.push_back({card_suit, card_rank});
        check("card timing", cyc, mon_e.at);
        check("cards_left with card", cards_left, mon_e.left);
        if (mon_e.any) begin
          check("rank in range", int'(card_rank >= 4'd1 && card_rank <= 4'd13), 1);
          check("card_value", card_value, (card_rank >= 4'd10) ? 10 : card_rank);
        end else begin
          check("card_rank", card_rank, mon_e.rank);
          check("card_suit", card_suit, mon_e.suit);
          check("card_value", card_value, mon_e.value);
        end
      end
    end
  end

  task automatic deal(input int k, input int left);
    @(negedge clk);
    req = 1'b1;
    if (k < 0) exp_q.push_back(wild(left, cyc + 1));
    else       exp_q.push_back(ord(k, left, cyc + 1));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic do_reset(input logic tm);
    @(negedge clk);
    reset = 1'b0; req = 1'b0; new_round = 1'b0; test_mode = tm;
    repeat (2) @(negedge clk);
    check("queue drained before reset", exp_q.size(), 0);
    check("reset card_valid", card_valid, 0);
    check("reset card_rank", card_rank, 0);
    check("reset card_suit", card_suit, 0);
    check("reset card_value", card_value, 0);
    check("reset cards_left", cards_left, 0);
    check("reset busy", busy, 1);
    cap_q.delete();
    reset = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_ready(output int fall);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy fall within bound", busy, 0);
    fall = cyc;
  endtask

  task automatic pulse_new_round();
    @(negedge clk);
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
  endtask

  // Shuffled run: 3 requests while busy, then the whole deck.
  task automatic shuffled_run();
    int fall;
    int distinct;
    bit seen [64];
    do_reset(1'b0);
    repeat (55) @(negedge clk);
    check("busy during shuffle", busy, 1);
    repeat (3) begin
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
    end
    wait_ready(fall);
    exp_q.push_back(wild(51, fall + 1));
    repeat (3) @(negedge clk);
    check("held request served once", exp_q.size(), 0);
    for (int k = 1; k < 52; k++) deal(-1, 51 - k);
    @(negedge clk);
    check("cards_left after full deal", cards_left, 0);
    check("captured card count", cap_q.size(), 52);
    foreach (seen[x]) seen[x] = 1'b0;
    distinct = 0;
    foreach (cap_q[x]) begin
      if (!seen[cap_q[x]]) distinct++;
      seen[cap_q[x]] = 1'b1;
    end
    check("distinct cards", distinct, 52);
  endtask

  initial begin
    int fall, t_req, diff;
    reset = 1'b0;

    // Test mode ordering.
    do_reset(1'b1);
    wait_ready(fall);
    check("fill latency", fall - rel_cyc, 52);
    for (int k = 0; k < 13; k++) deal(k, 51 - k);
    check("cards_left after 13", cards_left, 39);

    // Exhaustion refill.
    for (int k = 13; k < 52; k++) deal(k, 51 - k);
    check("cards_left empty", cards_left, 0);
    @(negedge clk);
    req = 1'b1; t_req = cyc;
    @(negedge clk);
    req = 1'b0;
    check("busy on exhaustion", busy, 1);
    wait_ready(fall);
    check("refill latency", fall - t_req, 53);
    exp_q.push_back(ord(0, 51, fall + 1));
    repeat (2) @(negedge clk);
    check("refill card delivered", exp_q.size(), 0);

    // Round boundary.
    for (int k = 1; k < 37; k++) deal(k, 51 - k);
    pulse_new_round();
    @(negedge clk);
    check("new_round at 15 busy", busy, 0);
    check("new_round at 15 cards_left", cards_left, 15);
    deal(37, 14);
    pulse_new_round();
    check("new_round at 14 busy", busy, 1);
    wait_ready(fall);
    check("cards_left after round refill", cards_left, 52);
    for (int k = 0; k < 37; k++) deal(k, 51 - k);
    @(negedge clk);
    req = 1'b1; new_round = 1'b1;
    exp_q.push_back(ord(37, 14, cyc + 1));
    @(negedge clk);
    req = 1'b0; new_round = 1'b0;
    check("deal with new_round busy", busy, 0);
    @(negedge clk);
    check("fill after deal+new_round", busy, 1);
    wait_ready(fall);
    check("cards_left after deferred refill", cards_left, 52);

    // Shuffled completeness and determinism.
    shuffled_run();
    ref_seq = cap_q;
    diff = 0;
    foreach (ref_seq[k]) if (ref_seq[k] != {2'(k / 13), 4'((k % 13) + 1)}) diff++;
    check("deck actually shuffled", int'(diff > 0), 1);
    shuffled_run();
    diff = 0;
    foreach (ref_seq[k]) if (k < cap_q.size() && ref_seq[k] != cap_q[k]) diff++;
    check("repeat sequence identical", diff, 0);

    // Reset during shuffle with a pending request.
    do_reset(1'b0);
    repeat (60) @(negedge clk);
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (5) @(negedge clk);
    do_reset(1'b0);
    wait_ready(fall);
    check("cards_left after shuffle reset", cards_left, 52);
    repeat (5) @(negedge clk);
    check("pending discarded (shuffle)", cap_q.size(), 0);

    // Reset in READY after 5 deals.
    for (int k = 0; k < 5; k++) deal(-1, 51 - k);
    @(negedge clk);
    check("cards_left after 5", cards_left, 47);
    do_reset(1'b0);
    wait_ready(fall);
    check("cards_left after ready reset", cards_left, 52);
    repeat (5) @(negedge clk);
    check("no stray card after reset", cap_q.size(), 0);
    check("scoreboard empty at end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Producer end of the card interface consumed by the blackjack game controller. Replaces the free-running card source with a real 52-card deck.
- Holds the deck in a register array, shuffles it with an LFSR-driven Fisher-Yates pass, and deals one card per request.
- Tracks the cards remaining and reshuffles on exhaustion, or at a round boundary when the deck runs low.
- Provides a deterministic test mode with an unshuffled deck.

Parameters:
- SEED, 16'hACE1, non-zero LFSR reset value.
- RESHUFFLE_AT, 15, at a new_round pulse, reshuffle if cards_left < RESHUFFLE_AT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- test_mode  in  1  1 = fill deck in fixed order and skip the shuffle; sampled at the start of every fill
- new_round  in  1  one-cycle pulse from the game FSM at the end of a round
- req  in  1  deal request; each cycle sampled high while ready deals one card
- card_valid  out  1  one-cycle pulse, card fields valid
- card_rank  out  4  1..13 (A=1, J=11, Q=12, K=13)
- card_suit  out  2  0..3
- card_value  out  4  blackjack value: rank for 1..9, 10 for rank >= 10
- cards_left  out  6  undealt cards, 0..52
- busy  out  1  high during fill/shuffle; requests are held, not dropped

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset is synchronous and active-low: all state updates when reset==0 at a rising clk edge.
- Reset values:
  - state=FILL, card_valid=0, card_rank=0, card_suit=0, card_value=0, cards_left=0, busy=1.
  - pend_req=0, pend_shuf=0, LFSR=SEED.
- Deck storage:
  - 52 x 6-bit entries, each encoded {suit[1:0], rank[3:0]}.
  - Dealing pointer ptr runs 0..52; cards_left = 52 - ptr.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle outside reset.
- FSM states: FILL, SHUFFLE, READY.
- FILL:
  - Writes one entry per cycle, index i = 0..51, in order suit 0 ranks 1..13, then suit 1, and so on. Takes 52 cycles.
  - On the last write: ptr=0, cards_left=52.
  - If test_mode=1, go to READY. Otherwise go to SHUFFLE with i=51.
- SHUFFLE (Fisher-Yates):
  - j = LFSR[5:0] & mask(i), where mask is the smallest 2^k-1 >= i.
  - If j <= i: swap deck[i] and deck[j] in the same cycle, then i--.
  - If j > i: reject and retry next cycle.
  - When i reaches 0, go to READY.
- READY:
  - req sampled high at edge N: card_valid=1 in cycle N+1 with deck[ptr] fields; ptr++.
  - card_valid is registered; card fields hold their last value until the next deal.
- busy = (state != READY), registered with the state.
- Request during busy:
  - Sets pend_req.
  - The first cycle in READY deals one card regardless of req; pend_req then clears.
  - Multiple requests while busy collapse to one.
- Exhaustion: req while ptr==52 sets pend_req and enters FILL. No card_valid until the refill completes.
- new_round in READY with no req:
  - If cards_left < RESHUFFLE_AT, enter FILL.
  - Otherwise no effect.
- new_round and req in the same cycle:
  - The deal is served.
  - If the reshuffle condition holds after the deal, set pend_shuf; the next cycle enters FILL.
- new_round while busy: ignored.
- Reset mid-FILL, mid-SHUFFLE or mid-deal:
  - Returns to reset values.
  - Any pending request is discarded and a full FILL/SHUFFLE restarts.
- Determinism: the same SEED, test_mode and stimulus timing give an identical card sequence.

Decomposition:
- Package bj_card_pkg:
  - DECK_SIZE=52, NUM_RANKS=13, NUM_SUITS=4.
  - card_t encoding {suit, rank}.
  - State enum {FILL, SHUFFLE, READY}.
  - Function rank_to_value (rank >= 10 -> 10).
- Sub-module bj_lfsr:
  - 16-bit LFSR.
  - Ports clk, reset, seed, q.
- Top level holds the deck array, FSM, pointer and pending flags.

Test Plan:
- Test mode ordering:
  - Stimulus: reset low 2 cycles with test_mode=1, release, wait for busy=0; then 13 single-cycle reqs.
  - Required: busy falls 52 cycles after reset release. Ranks 1..13 with suit 0; values 1,2,..,9,10,10,10,10; cards_left 51 down to 39; each card_valid exactly 1 cycle after its req.
- Shuffled deck completeness:
  - Stimulus: test_mode=0, deal 52 cards.
  - Required: each {suit, rank} appears exactly once; cards_left reaches 0.
  - Stimulus: repeat with the same SEED.
  - Required: identical sequence.
- Exhaustion refill:
  - Stimulus: test_mode=1, deal 52, then req.
  - Required: busy=1; after 52 cycles, card_valid with rank 1, suit 0; cards_left=51.
- Round-boundary reshuffle:
  - Stimulus: new_round at cards_left=14.
  - Required: FILL entered, busy=1.
  - Stimulus: new_round at cards_left=15.
  - Required: no change.
  - Stimulus: new_round together with req at cards_left=15.
  - Required: card dealt (cards_left 14), then FILL on the next cycle.
- Request while busy:
  - Stimulus: 3 req pulses during SHUFFLE.
  - Required: exactly one card_valid, 1 cycle after busy falls.
- Reset mid-operation:
  - Stimulus: assert reset during SHUFFLE and again during READY after 5 deals.
  - Required: outputs return to reset values; the deck refills and cards_left=52 after the reshuffle completes; pending request discarded.
